regfile_wr_demux: RTL and testbench

- Write-side demultiplexer and storage bank for the LEGv8 register file.
- One 64-bit writeback value is routed to one of 32 registers through a 5:32 one-hot decode. This is the inverse of the read-side mux tree.
- Writes are staged in a one-entry pending register and committed one cycle later.
- One combinational read port is provided so the bank can be checked in isolation.

---
 rtl/regfile_wr_demux.sv | 98 +++++++++
 tb/tb_regfile_wr_demux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_demux.sv
// rtl/regfile_wr_demux.sv - LEGv8 register file write demux with staged commit and one read port
//
// Purpose:
//   Routes one WIDTH-bit writeback value into one of 2**ADDR_W registers
//   through a one-hot decode. A write is captured into a one-entry pending
//   stage on one edge and committed to storage on the next edge, giving a
//   throughput of one write per cycle. Register ZERO_REG reads as zero and
//   is never written.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : a read of the pending (non-zero-register) address returns the
//               pending data, so read-after-write latency is one edge.
//   Undefined : reads always return committed storage.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   wr_en      in   write request this cycle
//   wr_addr    in   [ADDR_W-1:0] destination register index
//   wr_data    in   [WIDTH-1:0]  writeback value
//   rd_addr    in   [ADDR_W-1:0] read index
//   rd_data    out  [WIDTH-1:0]  combinational read value
//   wr_onehot  out  [2**ADDR_W-1:0] registered decode of the pending write
//   pend_valid out  a staged write awaits commit

module regfile_wr_demux #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [(1<<ADDR_W)-1:0]  wr_onehot,
  output logic                    pend_valid
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0]  storage [NREG];
  logic [ADDR_W-1:0] pend_addr;
  logic [WIDTH-1:0]  pend_data;
  logic [NREG-1:0]   decode;

  // 5:32 one-hot decode of the incoming write address.
  always_comb begin
    decode = '0;
    decode[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      wr_onehot  <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
      for (int i = 0; i < NREG; i++) begin
        storage[i] <= '0;
      end
    end else begin
      // Commit the older write while capturing the newer one on the same edge.
      // pend_addr is the encoded form of wr_onehot, so exactly one register is
      // selected; the zero register is captured but never stored.
      if (pend_valid && (pend_addr != ZERO_A)) begin
        storage[pend_addr] <= pend_data;
      end

      pend_valid <= wr_en;
      if (wr_en) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
        wr_onehot <= decode;
      end else begin
        wr_onehot <= '0;
      end
    end
  end

  // Zero-register rule has the highest priority, then bypass, then storage.
  always_comb begin
    rd_data = storage[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (pend_valid && (rd_addr == pend_addr) && (pend_addr != ZERO_A)) begin
      rd_data = pend_data;
    end
`else
`endif
    if (rd_addr == ZERO_A) begin
      rd_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_demux.sv
// tb/tb_regfile_wr_demux.sv - directed self-checking bench for regfile_wr_demux

module tb_regfile_wr_demux;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] wr_onehot;
  logic        pend_valid;

  int checks;
  int errors;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_wr_demux #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_onehot (wr_onehot),
    .pend_valid(pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [63:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hAA; rd_addr = 5'd0;
    tick();
    tick();
    checks++;
    if (pend_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pend_valid: got %b expected 0", pend_valid);
    end
    checks++;
    if (wr_onehot !== 32'h0) begin
      errors++; $display("FAIL reset_onehot: got %h expected 00000000", wr_onehot);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      checks++;
      if (v !== 64'h0) begin
        errors++; $display("FAIL reset_rd_x%0d: got %h expected 0", i, v);
      end
    end
    reset = 1'b1; wr_en = 1'b0;
    tick();
    tick();
    read_reg(5'd3, v);
    checks++;
    if (v !== 64'h0) begin
      errors++; $display("FAIL reset_release_x3: got %h expected 0", v);
    end
  endtask

  task automatic test_single_write();
    logic [63:0] v;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_onehot !== 32'h0000_0020) begin
      errors++; $display("FAIL single_onehot: got %h expected 00000020", wr_onehot);
    end
    checks++;
    if (pend_valid !== 1'b1) begin
      errors++; $display("FAIL single_pend: got %b expected 1", pend_valid);
    end
    read_reg(5'd5, v);
    checks++;
    if (v !== (BYPASS ? 64'h1234 : 64'h0)) begin
      errors++; $display("FAIL single_early_rd: got %h expected %h", v, BYPASS ? 64'h1234 : 64'h0);
    end
    tick();
    checks++;
    if (pend_valid !== 1'b0) begin
      errors++; $display("FAIL single_pend_clear: got %b expected 0", pend_valid);
    end
    checks++;
    if (wr_onehot !== 32'h0) begin
      errors++; $display("FAIL single_onehot_clear: got %h expected 00000000", wr_onehot);
    end
    read_reg(5'd5, v);
    checks++;
    if (v !== 64'h1234) begin
      errors++; $display("FAIL single_commit_rd: got %h expected 1234", v);
    end
  endtask

  task automatic test_zero_reg();
    logic [63:0] v;
    read_reg(5'd31, v);
    checks++;
    if (v !== 64'h0) begin
      errors++; $display("FAIL zero_rd_before: got %h expected 0", v);
    end
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_onehot !== 32'h8000_0000) begin
      errors++; $display("FAIL zero_onehot: got %h expected 80000000", wr_onehot);
    end
    checks++;
    if (pend_valid !== 1'b1) begin
      errors++; $display("FAIL zero_pend: got %b expected 1", pend_valid);
    end
    read_reg(5'd31, v);
    checks++;
    if (v !== 64'h0) begin
      errors++; $display("FAIL zero_rd_pending: got %h expected 0", v);
    end
    tick();
    checks++;
    if (wr_onehot !== 32'h0) begin
      errors++; $display("FAIL zero_onehot_clear: got %h expected 00000000", wr_onehot);
    end
    for (int c = 0; c < 2; c++) begin
      read_reg(5'd31, v);
      checks++;
      if (v !== 64'h0) begin
        errors++; $display("FAIL zero_rd_after%0d: got %h expected 0", c, v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    logic [4:0]  addrs [3];
    logic [63:0] datas [3];
    logic [31:0] ohs   [3];
    addrs = '{5'd7, 5'd7, 5'd8};
    datas = '{64'h1, 64'h2, 64'h3};
    ohs   = '{32'h0000_0080, 32'h0000_0080, 32'h0000_0100};
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = addrs[i]; wr_data = datas[i];
      tick();
      checks++;
      if (wr_onehot !== ohs[i] || pend_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_onehot%0d: got %h/%b expected %h/1", i, wr_onehot, pend_valid, ohs[i]);
      end
    end
    wr_en = 1'b0;
    // X7=1 committed; X7=2 committed at the X8 capture edge; X8 still pending.
    read_reg(5'd7, v);
    checks++;
    if (v !== 64'h2) begin
      errors++; $display("FAIL b2b_x7_mid: got %h expected 2", v);
    end
    tick();
    read_reg(5'd7, v);
    checks++;
    if (v !== 64'h2) begin
      errors++; $display("FAIL b2b_x7: got %h expected 2", v);
    end
    read_reg(5'd8, v);
    checks++;
    if (v !== 64'h3) begin
      errors++; $display("FAIL b2b_x8: got %h expected 3", v);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] v;
    rd_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hBEEF;
    tick();
    wr_en = 1'b0;
    read_reg(5'd9, v);
    checks++;
    if (v !== (BYPASS ? 64'hBEEF : 64'h0)) begin
      errors++; $display("FAIL bypass_early: got %h expected %h", v, BYPASS ? 64'hBEEF : 64'h0);
    end
    tick();
    read_reg(5'd9, v);
    checks++;
    if (v !== 64'hBEEF) begin
      errors++; $display("FAIL bypass_commit: got %h expected beef", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h55;
    tick();
    wr_en = 1'b0; reset = 1'b0;
    tick();
    checks++;
    if (pend_valid !== 1'b0 || wr_onehot !== 32'h0) begin
      errors++; $display("FAIL midrst_pend: got %b/%h expected 0/00000000", pend_valid, wr_onehot);
    end
    reset = 1'b1;
    tick();
    tick();
    read_reg(5'd4, v);
    checks++;
    if (v !== 64'h0) begin
      errors++; $display("FAIL midrst_x4: got %h expected 0", v);
    end
    read_reg(5'd9, v);
    checks++;
    if (v !== 64'h0) begin
      errors++; $display("FAIL midrst_x9_cleared: got %h expected 0", v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_single_write();
    test_zero_reg();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
